// File: rtl/control_wall.sv
// Scrolling-wall sequencer: each frame it erases the wall, moves it left, and
// redraws it with a hole, sharing the VGA plot port through a req/gnt handshake.
module control_wall #(
   parameter int          SCREEN_W     = 160,
   parameter int          SCREEN_H     = 120,
   parameter int          WALL_X_START = 100,
   parameter int          WALL_X_SPEED = 4,
   parameter int          WALL_WIDTH   = 10,
   parameter int          HOLE_HEIGHT  = 50,
   parameter logic [2:0]  WALL_COLOUR  = 3'b100,
   parameter logic [2:0]  BG_COLOUR    = 3'b111,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       enable,
   input  logic       gnt,
   output logic       req,
   output logic       plot,
   output logic [7:0] x_out,
   output logic [6:0] y_out,
   output logic [2:0] colour_out,
   output logic [7:0] wall_x,
   output logic [6:0] hole_y,
   output logic       wall_passed,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_ERASE,
      S_UPDATE,
      S_DRAW,
      S_RELEASE
   } state_t;

   localparam logic [7:0] COL_LAST   = 8'(WALL_WIDTH - 1);
   localparam logic [6:0] ROW_LAST   = 7'(SCREEN_H - 1);
   localparam logic [7:0] SPEED      = 8'(WALL_X_SPEED);
   localparam logic [7:0] WRAP_X     = 8'(SCREEN_W - WALL_WIDTH);
   localparam logic [7:0] START_X    = 8'(WALL_X_START);
   localparam logic [6:0] HOLE_RANGE = 7'(SCREEN_H - HOLE_HEIGHT);
   localparam logic [6:0] HOLE_INIT  = 7'((SCREEN_H - HOLE_HEIGHT) / 2);
   localparam logic [7:0] HOLE_SPAN  = 8'(HOLE_HEIGHT);
   localparam logic [7:0] SCREEN_W8  = 8'(SCREEN_W);

   state_t     state_q, state_d;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic [7:0] wall_x_q, wall_x_d;
   logic [6:0] hole_y_q, hole_y_d;
   logic [7:0] lfsr_q, lfsr_d;
   logic       wall_passed_q, wall_passed_d;

   logic [7:0] lfsr_step;
   logic [6:0] lfsr_r;
   logic       in_scan;
   logic       in_hole;
   logic [7:0] x_pix;
   logic [7:0] cy_ext;
   logic [7:0] hole_lo;
   logic [7:0] hole_hi;

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d       = state_q;
      cx_d          = cx_q;
      cy_d          = cy_q;
      wall_x_d      = wall_x_q;
      hole_y_d      = hole_y_q;
      lfsr_d        = lfsr_q;
      wall_passed_d = 1'b0;
      lfsr_step     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      lfsr_r        = lfsr_step[6:0];

      unique case (state_q)
         S_IDLE: begin
            if (frame_tick && enable) state_d = S_REQ;
         end
         S_REQ: begin
            if (gnt) begin
               cx_d    = '0;
               cy_d    = '0;
               state_d = S_ERASE;
            end
         end
         S_ERASE, S_DRAW: begin
            // Scan only advances while the arbiter grants the port.
            if (gnt) begin
               if (cx_q == COL_LAST) begin
                  cx_d = '0;
                  if (cy_q == ROW_LAST) begin
                     cy_d    = '0;
                     state_d = (state_q == S_ERASE) ? S_UPDATE : S_RELEASE;
                  end else begin
                     cy_d = cy_q + 7'd1;
                  end
               end else begin
                  cx_d = cx_q + 8'd1;
               end
            end
         end
         S_UPDATE: begin
            if (wall_x_q >= SPEED) begin
               wall_x_d = wall_x_q - SPEED;
            end else begin
               wall_x_d      = WRAP_X;
               wall_passed_d = 1'b1;
               lfsr_d        = lfsr_step;
               hole_y_d      = (lfsr_r < HOLE_RANGE) ? lfsr_r : lfsr_r - HOLE_RANGE;
            end
            cx_d    = '0;
            cy_d    = '0;
            state_d = S_DRAW;
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q       <= S_IDLE;
         cx_q          <= '0;
         cy_q          <= '0;
         wall_x_q      <= START_X;
         hole_y_q      <= HOLE_INIT;
         lfsr_q        <= LFSR_SEED;
         wall_passed_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         wall_x_q      <= wall_x_d;
         hole_y_q      <= hole_y_d;
         lfsr_q        <= lfsr_d;
         wall_passed_q <= wall_passed_d;
      end
   end

   // Pixel outputs decode straight from state and counters: no added latency.
   always_comb begin
      in_scan    = (state_q == S_ERASE) || (state_q == S_DRAW);
      x_pix      = wall_x_q + cx_q;
      cy_ext     = {1'b0, cy_q};
      hole_lo    = {1'b0, hole_y_q};
      hole_hi    = hole_lo + HOLE_SPAN;
      in_hole    = (cy_ext >= hole_lo) && (cy_ext < hole_hi);
      x_out      = in_scan ? x_pix : 8'd0;
      y_out      = in_scan ? cy_q : 7'd0;
      colour_out = (state_q == S_ERASE) ? BG_COLOUR :
                   (state_q == S_DRAW)  ? WALL_COLOUR : 3'b000;
      plot       = gnt && in_scan && (x_pix < SCREEN_W8) &&
                   !((state_q == S_DRAW) && in_hole);
   end

   assign req         = (state_q == S_REQ) || (state_q == S_ERASE) ||
                        (state_q == S_UPDATE) || (state_q == S_DRAW);
   assign busy        = (state_q != S_IDLE);
   assign wall_x      = wall_x_q;
   assign hole_y      = hole_y_q;
   assign wall_passed = wall_passed_q;

endmodule

// File: tb/tb_control_wall.sv
// Directed bench for control_wall: reset, a clean frame, grant stalls, blocked
// starts and the wall wrap with its new hole position.
module tb_control_wall;

   logic       clk = 1'b0;
   logic       reset;
   logic       frame_tick;
   logic       enable;
   logic       gnt;
   logic       req;
   logic       plot;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour_out;
   logic [7:0] wall_x;
   logic [6:0] hole_y;
   logic       wall_passed;
   logic       busy;

   always #5 clk = ~clk;

   control_wall dut (
      .clk         (clk),
      .reset       (reset),
      .frame_tick  (frame_tick),
      .enable      (enable),
      .gnt         (gnt),
      .req         (req),
      .plot        (plot),
      .x_out       (x_out),
      .y_out       (y_out),
      .colour_out  (colour_out),
      .wall_x      (wall_x),
      .hole_y      (hole_y),
      .wall_passed (wall_passed),
      .busy        (busy)
   );

   int total = 0;
   int bad   = 0;

   // Per-frame observations gathered by run_frame.
   int e_cnt, d_cnt, other_col;
   int e_xmin, e_xmax, e_ymin, e_ymax, d_xmin, d_xmax;
   int e_first_x, e_first_y, d_first_x, d_first_y;
   int hole_hits, busy_cyc, req_cyc, wp_cyc;
   int stall_cyc, stall_bad, resume_x, resume_y;
   int timed_out;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One frame_tick, then watch the whole sequence until busy drops.
   task automatic run_frame(input int drop_at, input int en_drop_at,
                            input bit extra_tick, input int hole_lo);
      int  gnt_left;
      int  budget;
      bit  dropped;
      bit  resume_pending;
      e_cnt = 0; d_cnt = 0; other_col = 0;
      e_xmin = 999; e_xmax = -1; e_ymin = 999; e_ymax = -1;
      d_xmin = 999; d_xmax = -1;
      e_first_x = -1; e_first_y = -1; d_first_x = -1; d_first_y = -1;
      hole_hits = 0; busy_cyc = 0; req_cyc = 0; wp_cyc = 0;
      stall_cyc = 0; stall_bad = 0; resume_x = -1; resume_y = -1;
      timed_out = 0;
      gnt_left = 0; budget = 0; dropped = 1'b0; resume_pending = 1'b0;

      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         if (budget >= 3000) begin
            timed_out = 1;
            break;
         end
         budget++;
         busy_cyc++;
         if (req) req_cyc++;
         if (wall_passed) wp_cyc++;
         if (gnt_left > 0) begin
            stall_cyc++;
            if (plot || x_out != 8'd103 || y_out != 7'd57 || !req) stall_bad++;
         end
         if (plot) begin
            if (colour_out == 3'b111) begin
               if (e_cnt == 0) begin
                  e_first_x = int'(x_out);
                  e_first_y = int'(y_out);
               end
               if (resume_pending) begin
                  resume_x = int'(x_out);
                  resume_y = int'(y_out);
                  resume_pending = 1'b0;
               end
               e_cnt++;
               if (int'(x_out) < e_xmin) e_xmin = int'(x_out);
               if (int'(x_out) > e_xmax) e_xmax = int'(x_out);
               if (int'(y_out) < e_ymin) e_ymin = int'(y_out);
               if (int'(y_out) > e_ymax) e_ymax = int'(y_out);
            end else if (colour_out == 3'b100) begin
               if (d_cnt == 0) begin
                  d_first_x = int'(x_out);
                  d_first_y = int'(y_out);
               end
               d_cnt++;
               if (int'(x_out) < d_xmin) d_xmin = int'(x_out);
               if (int'(x_out) > d_xmax) d_xmax = int'(x_out);
               if (int'(y_out) >= hole_lo && int'(y_out) < hole_lo + 50) hole_hits++;
            end else begin
               other_col++;
            end
         end
         @(posedge clk); #1;
         frame_tick = 1'b0;
         if (gnt_left > 0) begin
            gnt_left--;
            if (gnt_left == 0) begin
               gnt = 1'b1;
               resume_pending = 1'b1;
            end
         end else if (drop_at >= 0 && !dropped && e_cnt == drop_at) begin
            gnt      = 1'b0;
            gnt_left = 10;
            dropped  = 1'b1;
         end
         if (en_drop_at >= 0 && e_cnt == en_drop_at) enable = 1'b0;
         if (extra_tick && busy_cyc == 100) frame_tick = 1'b1;
      end
      frame_tick = 1'b0;
      check("frame_timeout", 32'(timed_out), 0);
   endtask

   initial begin
      int budget;
      int busy_seen;
      int wp_total;

      reset = 1'b1; frame_tick = 1'b0; enable = 1'b0; gnt = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req",        32'(req),         0);
      check("rst_plot",       32'(plot),        0);
      check("rst_busy",       32'(busy),        0);
      check("rst_wall_x",     32'(wall_x),      100);
      check("rst_hole_y",     32'(hole_y),      35);
      check("rst_wall_pass",  32'(wall_passed), 0);
      check("rst_x_out",      32'(x_out),       0);
      check("rst_y_out",      32'(y_out),       0);
      check("rst_colour",     32'(colour_out),  0);

      // Reset asserted mid-DRAW returns everything to the reset state.
      @(posedge clk); #1 reset = 1'b0; enable = 1'b1; gnt = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      budget = 0;
      while (!(plot && colour_out == 3'b100) && budget < 3000) begin
         @(negedge clk);
         budget++;
      end
      check("draw_reached", 32'(budget < 3000), 1);
      check("draw_wall_x",  32'(wall_x), 96);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("mid_rst_req",       32'(req),         0);
      check("mid_rst_plot",      32'(plot),        0);
      check("mid_rst_busy",      32'(busy),        0);
      check("mid_rst_wall_x",    32'(wall_x),      100);
      check("mid_rst_hole_y",    32'(hole_y),      35);
      check("mid_rst_wall_pass", 32'(wall_passed), 0);
      @(posedge clk); #1 reset = 1'b0;

      // Clean frame with a stray frame_tick while busy.
      run_frame(-1, -1, 1'b1, 35);
      check("f1_first_erase_x", 32'(e_first_x), 100);
      check("f1_first_erase_y", 32'(e_first_y), 0);
      check("f1_erase_cnt",     32'(e_cnt),     1200);
      check("f1_erase_xmin",    32'(e_xmin),    100);
      check("f1_erase_xmax",    32'(e_xmax),    109);
      check("f1_erase_ymin",    32'(e_ymin),    0);
      check("f1_erase_ymax",    32'(e_ymax),    119);
      check("f1_wall_x",        32'(wall_x),    96);
      check("f1_draw_cnt",      32'(d_cnt),     700);
      check("f1_first_draw_x",  32'(d_first_x), 96);
      check("f1_first_draw_y",  32'(d_first_y), 0);
      check("f1_draw_xmin",     32'(d_xmin),    96);
      check("f1_draw_xmax",     32'(d_xmax),    105);
      check("f1_hole_hits",     32'(hole_hits), 0);
      check("f1_other_colour",  32'(other_col), 0);
      check("f1_busy_cycles",   32'(busy_cyc),  2403);
      check("f1_req_cycles",    32'(req_cyc),   2402);
      check("f1_wall_passed",   32'(wp_cyc),    0);
      check("f1_req_after",     32'(req),       0);
      busy_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (busy) busy_seen++;
      end
      check("tick_while_busy_ignored", 32'(busy_seen), 0);

      // frame_tick with enable low in IDLE must not start a sequence.
      @(posedge clk); #1 enable = 1'b0; frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
      busy_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (req || busy) busy_seen++;
      end
      check("disabled_tick_req", 32'(busy_seen), 0);

      // Fresh reset, then a frame with a 10-cycle grant drop at (103,57)
      // and enable dropped mid-erase.
      @(posedge clk); #1 reset = 1'b1; enable = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      run_frame(573, 300, 1'b0, 35);
      check("stall_cycles",     32'(stall_cyc), 10);
      check("stall_frozen",     32'(stall_bad), 0);
      check("resume_x",         32'(resume_x),  103);
      check("resume_y",         32'(resume_y),  57);
      check("stall_erase_cnt",  32'(e_cnt),     1200);
      check("stall_busy_cyc",   32'(busy_cyc),  2413);
      check("en_drop_draw_cnt", 32'(d_cnt),     700);
      check("en_drop_wall_x",   32'(wall_x),    96);
      enable = 1'b1;

      // 24 more frames bring the wall to x=0 without a wrap.
      wp_total = 0;
      for (int f = 0; f < 24; f++) begin
         run_frame(-1, -1, 1'b0, 35);
         wp_total += wp_cyc;
      end
      check("pre_wrap_wall_x", 32'(wall_x),   0);
      check("pre_wrap_hole_y", 32'(hole_y),   35);
      check("pre_wrap_passes", 32'(wp_total), 0);

      // Wrap frame: LFSR A5 -> 4A, r = 74 -> hole_y = 4.
      run_frame(-1, -1, 1'b0, 4);
      check("wrap_erase_xmin",  32'(e_xmin),    0);
      check("wrap_erase_xmax",  32'(e_xmax),    9);
      check("wrap_wall_x",      32'(wall_x),    150);
      check("wrap_pass_cycles", 32'(wp_cyc),    1);
      check("wrap_hole_y",      32'(hole_y),    4);
      check("wrap_draw_cnt",    32'(d_cnt),     700);
      check("wrap_draw_xmin",   32'(d_xmin),    150);
      check("wrap_draw_xmax",   32'(d_xmax),    159);
      check("wrap_hole_hits",   32'(hole_hits), 0);
      check("wrap_first_draw",  32'(d_first_y), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
